// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus arbiter/sequencer.
// Covers FSM states, port indices, the cartridge RAM chip-select window and default phase lengths.
package cart_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [15:0] CS_LO = 16'hA000;
    localparam logic [15:0] CS_HI = 16'hFDFF;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    localparam int CNT_W = 8;

    // External RAM and the upper echo region are selected through cart_cs_n.
    function automatic logic in_cs_window(input logic [15:0] a);
        return (a >= CS_LO) && (a <= CS_HI);
    endfunction

    function automatic logic [1:0] port_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cart_bus_arb_if.sv
// Requester handshake plus cartridge pin bundle for cart_bus_arb.
// The master modport is the requester/cartridge side; the slave modport is the arbiter.
interface cart_bus_arb_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] cart_a;
    logic [7:0]  cart_dout;
    logic        cart_doe;
    logic [7:0]  cart_din;
    logic        cart_rd_n;
    logic        cart_wr_n;
    logic        cart_cs_n;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, cart_din,
        input  ack, rdata, busy, cart_a, cart_dout, cart_doe, cart_rd_n, cart_wr_n, cart_cs_n
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, cart_din,
        output ack, rdata, busy, cart_a, cart_dout, cart_doe, cart_rd_n, cart_wr_n, cart_cs_n
    );
endinterface

// File: rtl/cart_rr_arb2.sv
// Combinational 2-way round-robin picker; the last-grant state is held by the caller.
module cart_rr_arb2
    import cart_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // A tie goes to the port that did not win last time.
    always_comb begin
        grant = PORT_CPU;
        valid = 1'b0;
        case (req)
            2'b01: begin
                grant = PORT_CPU;
                valid = 1'b1;
            end
            2'b10: begin
                grant = PORT_DMA;
                valid = 1'b1;
            end
            2'b11: begin
                grant = ~last_grant;
                valid = 1'b1;
            end
            default: begin
                grant = PORT_CPU;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cart_bus_arb.sv
// Cartridge bus arbiter and SETUP/STROBE/HOLD access sequencer.
// All cartridge pins and requester responses are driven straight from flops.
module cart_bus_arb
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic         gb_clk,
    input  logic         gb_rst,
    cart_bus_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_r;
    logic               gnt_r;
    logic               we_r;
    logic [15:0]        cart_a_r;
    logic [7:0]         cart_dout_r;
    logic               cart_doe_r;
    logic               rd_n_r;
    logic               wr_n_r;
    logic               cs_n_r;
    logic [7:0]         rdata_r;
    logic [1:0]         ack_r;
    logic               busy_r;

    logic               pick_s;
    logic               pick_valid_s;
    logic               sel_we_s;
    logic [15:0]        sel_addr_s;
    logic [7:0]         sel_wdata_s;

    cart_rr_arb2 u_rr (
        .req        (bus.req),
        .last_grant (last_r),
        .grant      (pick_s),
        .valid      (pick_valid_s)
    );

    // Route the picked port's access description toward the latch in IDLE.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 16'h0000;
        sel_wdata_s = 8'h00;
        if (pick_s == PORT_DMA) begin
            sel_we_s    = bus.we[1];
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_we_s    = bus.we[0];
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Access sequencer; every pin is set on the edge that enters the state it belongs to.
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            last_r      <= PORT_DMA;
            gnt_r       <= PORT_CPU;
            we_r        <= 1'b0;
            cart_a_r    <= 16'h0000;
            cart_dout_r <= 8'h00;
            cart_doe_r  <= 1'b0;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            cs_n_r      <= 1'b1;
            rdata_r     <= 8'h00;
            ack_r       <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            ack_r <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_r     <= SETUP;
                        cnt_r       <= SETUP_LOAD;
                        last_r      <= pick_s;
                        gnt_r       <= pick_s;
                        we_r        <= sel_we_s;
                        cart_a_r    <= sel_addr_s;
                        cart_dout_r <= sel_we_s ? sel_wdata_s : 8'h00;
                        cart_doe_r  <= sel_we_s;
                        cs_n_r      <= ~in_cs_window(sel_addr_s);
                        busy_r      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_r == '0) begin
                        state_r <= STROBE;
                        cnt_r   <= STROBE_LOAD;
                        rd_n_r  <= we_r;
                        wr_n_r  <= ~we_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STROBE: begin
                    if (cnt_r == '0) begin
                        // Strobe release here gives the mapper its latching edge with address/data still stable.
                        state_r <= HOLD;
                        cnt_r   <= HOLD_LOAD;
                        rd_n_r  <= 1'b1;
                        wr_n_r  <= 1'b1;
                        if (!we_r) begin
                            rdata_r <= bus.cart_din;
                        end
                        if (HOLD_LOAD == '0) begin
                            ack_r <= port_onehot(gnt_r);
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_r == '0) begin
                        state_r     <= IDLE;
                        cart_doe_r  <= 1'b0;
                        cart_dout_r <= 8'h00;
                        cs_n_r      <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            ack_r <= port_onehot(gnt_r);
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rd_n_r     <= 1'b1;
                    wr_n_r     <= 1'b1;
                    cs_n_r     <= 1'b1;
                    cart_doe_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_r;
    assign bus.rdata     = rdata_r;
    assign bus.busy      = busy_r;
    assign bus.cart_a    = cart_a_r;
    assign bus.cart_dout = cart_dout_r;
    assign bus.cart_doe  = cart_doe_r;
    assign bus.cart_rd_n = rd_n_r;
    assign bus.cart_wr_n = wr_n_r;
    assign bus.cart_cs_n = cs_n_r;

endmodule

// File: tb/tb_cart_bus_arb.sv
// Randomized bench for cart_bus_arb: default timing (u0) and 2/3/2 timing (u1)
// checked every cycle against an access-offset reference model.
module tb_cart_bus_arb;
    import cart_bus_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } acc_t;

    typedef struct packed {
        logic [1:0]  ack;
        logic [7:0]  rdata;
        logic        busy;
        logic [15:0] cart_a;
        logic [7:0]  cart_dout;
        logic        cart_doe;
        logic        rd_n;
        logic        wr_n;
        logic        cs_n;
    } obs_t;

    logic gb_clk = 1'b0;
    logic gb_rst = 1'b1;

    cart_bus_arb_if b0 ();
    cart_bus_arb_if b1 ();

    cart_bus_arb u0 (.gb_clk(gb_clk), .gb_rst(gb_rst), .bus(b0.slave));
    cart_bus_arb #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2))
        u1 (.gb_clk(gb_clk), .gb_rst(gb_rst), .bus(b1.slave));

    logic [1:0]  d_req   [2];
    logic [1:0]  d_we    [2];
    logic [15:0] d_addr  [2][2];
    logic [7:0]  d_wdata [2][2];
    logic [7:0]  d_din   [2];
    obs_t        obs     [2];

    assign b0.req = d_req[0];   assign b0.we = d_we[0];
    assign b0.addr0 = d_addr[0][0];   assign b0.addr1 = d_addr[0][1];
    assign b0.wdata0 = d_wdata[0][0]; assign b0.wdata1 = d_wdata[0][1];
    assign b0.cart_din = d_din[0];
    assign b1.req = d_req[1];   assign b1.we = d_we[1];
    assign b1.addr0 = d_addr[1][0];   assign b1.addr1 = d_addr[1][1];
    assign b1.wdata0 = d_wdata[1][0]; assign b1.wdata1 = d_wdata[1][1];
    assign b1.cart_din = d_din[1];
    assign obs[0] = {b0.ack, b0.rdata, b0.busy, b0.cart_a, b0.cart_dout, b0.cart_doe,
                     b0.cart_rd_n, b0.cart_wr_n, b0.cart_cs_n};
    assign obs[1] = {b1.ack, b1.rdata, b1.busy, b1.cart_a, b1.cart_dout, b1.cart_doe,
                     b1.cart_rd_n, b1.cart_wr_n, b1.cart_cs_n};

    initial forever #5 gb_clk = ~gb_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: m_off is the cycle number within the current access (0 = idle).
    int          m_off   [2];
    logic        m_port  [2];
    logic        m_we    [2];
    logic        m_last  [2];
    logic [15:0] m_addr  [2];
    logic [7:0]  m_wdata [2];
    logic [7:0]  m_rdata [2];

    acc_t qs [4][$];
    bit   eager = 1'b1;
    bit   drop_flag = 1'b0;

    function automatic int s_of(int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int t_of(int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int h_of(int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int len_of(int i); return s_of(i) + t_of(i) + h_of(i); endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(int i);
        m_off[i]   = 0;
        m_port[i]  = 1'b0;
        m_we[i]    = 1'b0;
        m_last[i]  = 1'b1;
        m_addr[i]  = 16'h0000;
        m_wdata[i] = 8'h00;
        m_rdata[i] = 8'h00;
    endtask

    task automatic model_advance(int i);
        logic p;
        if (m_off[i] == 0) begin
            if (d_req[i] != 2'b00) begin
                p = (d_req[i] == 2'b11) ? ~m_last[i] : d_req[i][1];
                m_last[i]  = p;
                m_port[i]  = p;
                m_we[i]    = d_we[i][p];
                m_addr[i]  = d_addr[i][p];
                m_wdata[i] = d_wdata[i][p];
                m_off[i]   = 1;
            end
        end else if (m_off[i] == len_of(i)) begin
            m_off[i] = 0;
        end else begin
            if (m_off[i] == s_of(i) + t_of(i) && !m_we[i]) m_rdata[i] = d_din[i];
            m_off[i]++;
        end
    endtask

    task automatic compare(int i);
        bit act, on, win;
        string u;
        u   = $sformatf("u%0d.", i);
        on  = (m_off[i] != 0);
        act = (m_off[i] > s_of(i)) && (m_off[i] <= s_of(i) + t_of(i));
        win = (m_addr[i] >= 16'hA000) && (m_addr[i] <= 16'hFDFF);
        check_val({u, "ack"},    32'(obs[i].ack),
                  (m_off[i] == len_of(i)) ? (m_port[i] ? 32'd2 : 32'd1) : 32'd0);
        check_val({u, "busy"},   32'(obs[i].busy),   32'(on));
        check_val({u, "rd_n"},   32'(obs[i].rd_n),   32'(!(act && !m_we[i])));
        check_val({u, "wr_n"},   32'(obs[i].wr_n),   32'(!(act && m_we[i])));
        check_val({u, "cs_n"},   32'(obs[i].cs_n),   32'(!(on && win)));
        check_val({u, "doe"},    32'(obs[i].cart_doe), 32'(on && m_we[i]));
        check_val({u, "cart_a"}, 32'(obs[i].cart_a), 32'(m_addr[i]));
        check_val({u, "rdata"},  32'(obs[i].rdata),  32'(m_rdata[i]));
        if (on && m_we[i]) check_val({u, "dout"}, 32'(obs[i].cart_dout), 32'(m_wdata[i]));
    endtask

    task automatic load(int i, int p);
        acc_t a;
        a = qs[i*2+p].pop_front();
        d_req[i][p]   = 1'b1;
        d_we[i][p]    = a.we;
        d_addr[i][p]  = a.addr;
        d_wdata[i][p] = a.wdata;
    endtask

    task automatic drive(int i);
        bit mine;
        d_din[i] = 8'($urandom);
        for (int p = 0; p < 2; p++) begin
            mine = (m_off[i] != 0) && (int'(m_port[i]) == p);
            if (mine && m_off[i] == len_of(i)) begin
                if (qs[i*2+p].size() > 0) load(i, p);
                else d_req[i][p] = 1'b0;
            end else if (!d_req[i][p] && !mine && qs[i*2+p].size() > 0
                         && (eager || $urandom_range(0, 1) == 1)) begin
                load(i, p);
            end
            if (drop_flag && i == 0 && mine && m_off[i] == s_of(i) + 1 && d_req[i][p]) begin
                d_req[i][p]  = 1'b0;
                d_addr[i][p] = 16'($urandom);
                drop_flag    = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge gb_clk);
        for (int i = 0; i < 2; i++) begin
            if (gb_rst) model_reset(i);
            else model_advance(i);
            compare(i);
            drive(i);
        end
    endtask

    task automatic push(int i, int p, logic we, logic [15:0] addr, logic [7:0] wdata);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata;
        qs[i*2+p].push_back(a);
    endtask

    task automatic push_both(int p, logic we, logic [15:0] addr, logic [7:0] wdata);
        push(0, p, we, addr, wdata);
        push(1, p, we, addr, wdata);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (m_off[i] != 0 || d_req[i] != 2'b00) done = 1'b0;
                for (int p = 0; p < 2; p++) if (qs[i*2+p].size() > 0) done = 1'b0;
            end
        end
        check_val({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] a;
        case ($urandom_range(0, 7))
            0: a = 16'h9FFF;
            1: a = 16'hA000;
            2: a = 16'hFDFF;
            3: a = 16'hFE00;
            default: a = 16'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            d_req[i] = 2'b00; d_we[i] = 2'b00; d_din[i] = 8'h00;
            for (int p = 0; p < 2; p++) begin
                d_addr[i][p] = 16'h0000; d_wdata[i][p] = 8'h00;
            end
        end

        // Contention from reset: both ports hold req; acks must alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            push_both(0, 1'b0, pick_addr(), 8'h00);
            push_both(1, 1'b1, pick_addr(), 8'($urandom));
        end
        repeat (3) step();
        gb_rst = 1'b0;
        run_until_idle("contend", 200);

        // Single read/write and chip-select window boundaries.
        push_both(0, 1'b0, 16'h4123, 8'h00);
        push_both(1, 1'b1, 16'h2000, 8'h07);
        push_both(0, 1'b0, 16'hA010, 8'h00);
        push_both(0, 1'b0, 16'h9FFF, 8'h00);
        push_both(0, 1'b0, 16'hFE00, 8'h00);
        push_both(0, 1'b0, 16'hA000, 8'h00);
        push_both(0, 1'b1, 16'hFDFF, 8'hC3);
        run_until_idle("directed", 200);

        // Port 0 drops req during STROBE; the access must still finish and ack.
        drop_flag = 1'b1;
        push_both(0, 1'b0, 16'h4123, 8'h00);
        run_until_idle("drop", 50);

        // Reset asserted during STROBE: strobes release at once and no ack appears.
        push_both(1, 1'b1, 16'h2000, 8'h5A);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            found = (m_off[0] == s_of(0) + 1);
        end
        check_val("rst_reach_strobe", 32'(found), 32'd1);
        #2 gb_rst = 1'b1;
        #1;
        check_val("rst_wr_n", 32'(obs[0].wr_n), 32'd1);
        check_val("rst_rd_n", 32'(obs[0].rd_n), 32'd1);
        check_val("rst_ack",  32'(obs[0].ack),  32'd0);
        check_val("rst_busy", 32'(obs[0].busy), 32'd0);
        check_val("rst_cs_n", 32'(obs[0].cs_n), 32'd1);
        repeat (2) step();
        gb_rst = 1'b0;
        run_until_idle("post_rst", 50);

        // Randomized traffic with gaps and back-to-back requests.
        eager = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int q = 0; q < 4; q++) begin
                if (qs[q].size() < 2 && $urandom_range(0, 3) == 0) begin
                    acc_t a;
                    a.we = 1'($urandom);
                    a.addr = pick_addr();
                    a.wdata = 8'($urandom);
                    qs[q].push_back(a);
                end
            end
            step();
        end
        run_until_idle("random", 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
